// File: rtl/rle_encoder.sv
// Run-length encoder: captures one zigzag-ordered 8x8 coefficient block and
// emits (run, value) symbols with DC, ZRL and EOB markers over valid/ready.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; block buffer and nonzero mask load on start
// DC    | presenting the DC coefficient (always emitted)
// SCAN  | walking AC[1..63], one index per cycle; emits values and ZRLs
// EOB   | presenting end-of-block after the last nonzero AC
module rle_encoder #(
  parameter int W     = 21,
  parameter int NCOEF = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NCOEF*W-1:0] coeff_in,
  output logic               busy,
  output logic               sym_valid,
  input  logic               sym_ready,
  output logic [3:0]         sym_run,
  output logic [W-1:0]       sym_value,
  output logic               sym_dc,
  output logic               sym_eob,
  output logic               sym_last
);

  typedef enum logic [1:0] {IDLE, DC, SCAN, EOB} state_t;

  typedef struct packed {
    logic         valid;
    logic [3:0]   run;
    logic [W-1:0] value;
    logic         dc;
    logic         eob;
    logic         last;
  } sym_t;

  state_t             state, state_n;
  logic [5:0]         idx, idx_n;
  logic [3:0]         run_cnt, run_n;
  logic [63:1]        nz_mask, mask_in;
  logic [NCOEF*W-1:0] coef_buf;

  logic               load, hs;
  logic [W-1:0]       cur_val, next_val;
  logic               cur_rem, next_rem;
  sym_t               sym_n;

  // Any nonzero AC at index i or above.
  function automatic logic remaining(input logic [63:1] m, input logic [5:0] i);
    logic r;
    r = 1'b0;
    for (int j = 1; j < 64; j++) begin
      if (j >= int'(i) && m[j]) r = 1'b1;
    end
    return r;
  endfunction

  // Symbol presented for a given machine state; pure function of the state regs.
  function automatic sym_t present(input state_t s, input logic [5:0] i,
                                   input logic [3:0] r, input logic [W-1:0] v,
                                   input logic rem);
    sym_t o;
    o = '0;
    case (s)
      DC: begin
        o.valid = 1'b1;
        o.value = v;
        o.dc    = 1'b1;
      end
      SCAN: begin
        if (rem && v != '0) begin
          o.valid = 1'b1;
          o.run   = r;
          o.value = v;
          o.last  = (i == 6'd63);
        end else if (rem && r == 4'd15) begin
          o.valid = 1'b1;
          o.run   = 4'd15;
        end
      end
      EOB: begin
        o.valid = 1'b1;
        o.eob   = 1'b1;
        o.last  = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    mask_in = '0;
    for (int k = 1; k < 64; k++) begin
      mask_in[k] = |coeff_in[k*W +: W];
    end
  end

  assign load    = (state == IDLE) && start;
  assign hs      = sym_valid && sym_ready;
  assign cur_val = coef_buf[int'(idx)*W +: W];
  assign cur_rem = remaining(nz_mask, idx);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    run_n   = run_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DC;
          idx_n   = 6'd0;
          run_n   = 4'd0;
        end
      end
      DC: begin
        if (hs) begin
          state_n = SCAN;
          idx_n   = 6'd1;
          run_n   = 4'd0;
        end
      end
      SCAN: begin
        if (!cur_rem) begin
          state_n = EOB;
        end else if (cur_val != '0) begin
          if (hs) begin
            run_n = 4'd0;
            if (idx == 6'd63) state_n = IDLE;
            else              idx_n   = idx + 6'd1;
          end
        end else if (run_cnt == 4'd15) begin
          if (hs) begin
            run_n = 4'd0;
            idx_n = idx + 6'd1;
          end
        end else begin
          run_n = run_cnt + 4'd1;
          idx_n = idx + 6'd1;
        end
      end
      EOB: begin
        if (hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // On a load the next state is DC, which ignores the mask, so the old mask is safe here.
  assign next_val = load ? coeff_in[W-1:0] : coef_buf[int'(idx_n)*W +: W];
  assign next_rem = remaining(nz_mask, idx_n);
  assign sym_n    = present(state_n, idx_n, run_n, next_val, next_rem);

  always_ff @(posedge clk) begin
    if (load) coef_buf <= coeff_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      run_cnt   <= '0;
      nz_mask   <= '0;
      busy      <= 1'b0;
      sym_valid <= 1'b0;
      sym_run   <= '0;
      sym_value <= '0;
      sym_dc    <= 1'b0;
      sym_eob   <= 1'b0;
      sym_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      run_cnt   <= run_n;
      if (load) nz_mask <= mask_in;
      busy      <= (state_n != IDLE);
      sym_valid <= sym_n.valid;
      sym_run   <= sym_n.run;
      sym_value <= sym_n.value;
      sym_dc    <= sym_n.dc;
      sym_eob   <= sym_n.eob;
      sym_last  <= sym_n.last;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder: directed blocks push expected symbols,
// a negedge monitor pops and compares on every handshake.
module tb_rle_encoder;
  localparam int W     = 21;
  localparam int NCOEF = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [NCOEF*W-1:0] coeff_in;
  logic               busy, sym_valid, sym_dc, sym_eob, sym_last;
  logic               sym_ready = 1'b1;
  logic [3:0]         sym_run;
  logic [W-1:0]       sym_value;

  rle_encoder #(.W(W), .NCOEF(NCOEF)) dut (
    .clk(clk), .reset(reset), .start(start), .coeff_in(coeff_in),
    .busy(busy), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_run(sym_run), .sym_value(sym_value), .sym_dc(sym_dc),
    .sym_eob(sym_eob), .sym_last(sym_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   run;
    logic [W-1:0] value;
    logic         dc;
    logic         eob;
    logic         last;
  } sym_t;

  sym_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pop_cnt = 0;

  // Ready pattern with several multi-cycle stalls, including 5-cycle ones.
  int          ready_mode = 0;
  logic [4:0]  ready_idx = '0;
  logic [31:0] ready_pat = 32'b1011_0000_0110_1000_0011_1110_0000_1101;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) sym_ready = 1'b1;
    else begin
      sym_ready = ready_pat[ready_idx];
      ready_idx = ready_idx + 5'd1;
    end
  end

  sym_t cur, held, e;
  logic hold_pend = 1'b0;

  always @(negedge clk) begin
    cur = {sym_run, sym_value, sym_dc, sym_eob, sym_last};
    if (!reset) hold_pend = 1'b0;
    else begin
      if (hold_pend) begin
        tests++;
        if (cur !== held) begin
          fails++;
          $display("FAIL stall_hold: got %h, required %h", cur, held);
        end
      end
      hold_pend = 1'b0;
      if (sym_valid) begin
        if (sym_ready) begin
          tests++;
          pop_cnt++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_symbol: got %h, required none", cur);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              fails++;
              $display("FAIL symbol: got run=%0d value=%h dc=%b eob=%b last=%b, required run=%0d value=%h dc=%b eob=%b last=%b",
                       cur.run, cur.value, cur.dc, cur.eob, cur.last,
                       e.run, e.value, e.dc, e.eob, e.last);
            end
          end
        end else begin
          held = cur;
          hold_pend = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int run, input int value, input bit dc, input bit eob, input bit last);
    sym_t s;
    s.run   = 4'(run);
    s.value = W'(value);
    s.dc    = dc;
    s.eob   = eob;
    s.last  = last;
    exp_q.push_back(s);
  endtask

  task automatic set_coef(input int k, input int v);
    coeff_in[k*W +: W] = W'(v);
  endtask

  task automatic start_block();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency_valid", {63'd0, sym_valid}, 64'd1);
    check("latency_busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=1, required busy=0 within 3000 cycles", name);
    end else begin
      check({name, "_valid_drop"}, {63'd0, sym_valid}, 64'd0);
      check({name, "_queue_empty"}, exp_q.size(), 64'd0);
    end
  endtask

  task automatic load_ac1_block();
    coeff_in = '0;
    set_coef(0, -5);
    set_coef(1, 3);
    set_coef(4, -7);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    coeff_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, sym_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_flags", {61'd0, sym_dc, sym_eob, sym_last}, 64'd0);
    check("rst_run", {60'd0, sym_run}, 64'd0);
    check("rst_value", {43'd0, sym_value}, 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", {63'd0, sym_valid}, 64'd0);

    // All-zero block: DC then EOB.
    coeff_in = '0;
    push(0, 0, 1, 0, 0);
    push(0, 0, 0, 1, 1);
    start_block();
    wait_done("zero_block");

    // DC=-5, AC1=3, AC4=-7.
    load_ac1_block();
    push(0, -5, 1, 0, 0);
    push(0, 3, 0, 0, 0);
    push(2, -7, 0, 0, 0);
    push(0, 0, 0, 1, 1);
    start_block();
    wait_done("ac1_block");

    // Only AC63 nonzero: three ZRLs, last on coefficient 63, no EOB.
    coeff_in = '0;
    set_coef(0, 1);
    set_coef(63, 9);
    push(0, 1, 1, 0, 0);
    push(15, 0, 0, 0, 0);
    push(15, 0, 0, 0, 0);
    push(15, 0, 0, 0, 0);
    push(14, 9, 0, 0, 1);
    start_block();
    wait_done("ac63_block");

    // AC17 after exactly 16 zeros: one ZRL.
    coeff_in = '0;
    set_coef(0, 2);
    set_coef(17, 4);
    push(0, 2, 1, 0, 0);
    push(15, 0, 0, 0, 0);
    push(0, 4, 0, 0, 0);
    push(0, 0, 0, 1, 1);
    start_block();
    wait_done("zrl_block");

    // Backpressure on the AC1 block, with a spurious start mid-block.
    ready_mode = 1;
    load_ac1_block();
    push(0, -5, 1, 0, 0);
    push(0, 3, 0, 0, 0);
    push(2, -7, 0, 0, 0);
    push(0, 0, 0, 1, 1);
    start_block();
    repeat (4) @(negedge clk);
    check("busy_at_spurious_start", {63'd0, busy}, 64'd1);
    coeff_in = '0;
    set_coef(0, 77);
    set_coef(2, 55);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("stall_block");
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Reset mid-block after the second symbol.
    load_ac1_block();
    push(0, -5, 1, 0, 0);
    push(0, 3, 0, 0, 0);
    push(2, -7, 0, 0, 0);
    push(0, 0, 0, 1, 1);
    pop_cnt = 0;
    start_block();
    begin
      int n = 0;
      while (pop_cnt < 2 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("reset_reach_second", {63'd0, pop_cnt >= 2}, 64'd1);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_valid", {63'd0, sym_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", {63'd0, sym_valid}, 64'd0);
    check("post_rst_busy", {63'd0, busy}, 64'd0);

    coeff_in = '0;
    set_coef(0, 2);
    set_coef(17, 4);
    push(0, 2, 1, 0, 0);
    push(15, 0, 0, 0, 0);
    push(0, 4, 0, 0, 0);
    push(0, 0, 0, 1, 1);
    start_block();
    wait_done("after_reset_block");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
